// File: rtl/branch_resolver_if.sv
// Redirect channel between the execute-stage branch resolver and the Fetch Unit.
// The master drives the corrected PC and flush; the Fetch Unit answers with ready.
interface branch_resolver_if #(
   parameter int XLEN = 32
);
   logic            redirectValid;
   logic [XLEN-1:0] redirectPc;
   logic            flush;
   logic            redirectReady;

   modport master (
      output redirectValid,
      output redirectPc,
      output flush,
      input  redirectReady
   );

   modport slave (
      input  redirectValid,
      input  redirectPc,
      input  flush,
      output redirectReady
   );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: checks the fetch prediction for JAL/JALR/branches,
// requests a fetch redirect and flush on a mispredict, and keeps saturating statistics.
module branch_resolver #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               i_instr_valid,
   input  logic               i_stall,
   input  logic [XLEN-1:0]    i_pc,
   input  logic               i_is_op_branch,
   input  logic               i_is_op_jal,
   input  logic               i_is_op_jalr,
   input  logic [2:0]         i_funct3,
   input  logic [XLEN-1:0]    i_rs1_data,
   input  logic [XLEN-1:0]    i_rs2_data,
   input  logic [XLEN-1:0]    i_immB,
   input  logic [XLEN-1:0]    i_immJ,
   input  logic [XLEN-1:0]    i_immI,
   input  logic               i_pred_taken,
   input  logic               i_cnt_clr,
   branch_resolver_if.master  redir,
   output logic [CNT_W-1:0]   o_br_count,
   output logic [CNT_W-1:0]   o_mp_count
);

   typedef enum logic [1:0] {
      IDLE,
      REDIRECT,
      SQUASH
   } state_t;

   state_t            state_q;
   logic              redirectValid_q;
   logic              flush_q;
   logic [XLEN-1:0]   redirectPc_q;
   logic [XLEN-1:0]   redirectPc_d;
   logic [CNT_W-1:0]  brCount_q;
   logic [CNT_W-1:0]  mpCount_q;

   logic              isControl;
   logic              resolveEvent;
   logic              condTaken;
   logic              actualTaken;
   logic              mispredict;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   fallThrough;
   logic [XLEN-1:0]   jalrSum;

   assign isControl    = i_is_op_branch | i_is_op_jal | i_is_op_jalr;
   assign resolveEvent = i_instr_valid & ~i_stall & (state_q == IDLE)
                         & (isControl | i_pred_taken);
   assign fallThrough  = i_pc + XLEN'(4);
   assign jalrSum      = i_rs1_data + i_immI;

   // Outcome, target and mispredict decision for the instruction at the resolve stage.
   // A non-control instruction only reaches a resolve event when predicted taken,
   // so it always mispredicts and falls through.
   always_comb begin
      condTaken   = 1'b0;
      actualTaken = 1'b0;
      target      = fallThrough;
      mispredict  = i_pred_taken;
      unique case (i_funct3)
         3'b000:  condTaken = (i_rs1_data == i_rs2_data);
         3'b001:  condTaken = (i_rs1_data != i_rs2_data);
         3'b100:  condTaken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
         3'b101:  condTaken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
         3'b110:  condTaken = (i_rs1_data <  i_rs2_data);
         3'b111:  condTaken = (i_rs1_data >= i_rs2_data);
         default: condTaken = 1'b0;
      endcase
      if (i_is_op_jalr) begin
         actualTaken = 1'b1;
         target      = {jalrSum[XLEN-1:1], 1'b0};
         mispredict  = 1'b1;
      end else if (i_is_op_jal) begin
         actualTaken = 1'b1;
         target      = i_pc + i_immJ;
         mispredict  = ~i_pred_taken;
      end else if (i_is_op_branch) begin
         actualTaken = condTaken;
         target      = i_pc + i_immB;
         mispredict  = (condTaken != i_pred_taken);
      end
      redirectPc_d = actualTaken ? target : fallThrough;
   end

   // Recovery sequencer: hold the redirect until fetch accepts it, then keep flushing
   // for one extra cycle to drain the last wrong-path slot.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q         <= IDLE;
         redirectValid_q <= 1'b0;
         flush_q         <= 1'b0;
         redirectPc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (resolveEvent && mispredict) begin
                  state_q         <= REDIRECT;
                  redirectValid_q <= 1'b1;
                  flush_q         <= 1'b1;
                  redirectPc_q    <= redirectPc_d;
               end
            end
            REDIRECT: begin
               if (redir.redirectReady) begin
                  state_q         <= SQUASH;
                  redirectValid_q <= 1'b0;
               end
            end
            SQUASH: begin
               state_q <= IDLE;
               flush_q <= 1'b0;
            end
            default: begin
               state_q         <= IDLE;
               redirectValid_q <= 1'b0;
               flush_q         <= 1'b0;
            end
         endcase
      end
   end

   // Saturating statistics; a clear wins over any increment in the same cycle.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         brCount_q <= '0;
         mpCount_q <= '0;
      end else if (i_cnt_clr) begin
         brCount_q <= '0;
         mpCount_q <= '0;
      end else begin
         if (resolveEvent && isControl && (brCount_q != '1)) begin
            brCount_q <= brCount_q + 1'b1;
         end
         if (resolveEvent && mispredict && (mpCount_q != '1)) begin
            mpCount_q <= mpCount_q + 1'b1;
         end
      end
   end

   assign redir.redirectValid = redirectValid_q;
   assign redir.redirectPc    = redirectPc_q;
   assign redir.flush         = flush_q;
   assign o_br_count          = brCount_q;
   assign o_mp_count          = mpCount_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver, built with 4-bit counters so
// saturation is reachable in a handful of cycles.
module tb_branch_resolver;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   localparam int K_NONE = 0;
   localparam int K_BR   = 1;
   localparam int K_JAL  = 2;
   localparam int K_JALR = 3;

   logic              clk;
   logic              aresetn;
   logic              instrValid;
   logic              stall;
   logic [XLEN-1:0]   pc;
   logic              isBranch;
   logic              isJal;
   logic              isJalr;
   logic [2:0]        funct3;
   logic [XLEN-1:0]   rs1;
   logic [XLEN-1:0]   rs2;
   logic [XLEN-1:0]   immB;
   logic [XLEN-1:0]   immJ;
   logic [XLEN-1:0]   immI;
   logic              predTaken;
   logic              cntClr;
   logic [CNT_W-1:0]  brCount;
   logic [CNT_W-1:0]  mpCount;

   int checks;
   int passes;

   branch_resolver_if #(.XLEN(XLEN)) redirIf ();

   branch_resolver #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .aresetn        (aresetn),
      .i_instr_valid  (instrValid),
      .i_stall        (stall),
      .i_pc           (pc),
      .i_is_op_branch (isBranch),
      .i_is_op_jal    (isJal),
      .i_is_op_jalr   (isJalr),
      .i_funct3       (funct3),
      .i_rs1_data     (rs1),
      .i_rs2_data     (rs2),
      .i_immB         (immB),
      .i_immJ         (immJ),
      .i_immI         (immI),
      .i_pred_taken   (predTaken),
      .i_cnt_clr      (cntClr),
      .redir          (redirIf.master),
      .o_br_count     (brCount),
      .o_mp_count     (mpCount)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents one instruction at the resolve stage; imm feeds every immediate port.
   task automatic applyStimulus(input logic valid, input int kind, input logic [2:0] f3,
                                input logic [XLEN-1:0] pcIn, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                                input logic pred);
      instrValid = valid;
      isBranch   = (kind == K_BR);
      isJal      = (kind == K_JAL);
      isJalr     = (kind == K_JALR);
      funct3     = f3;
      pc         = pcIn;
      rs1        = a;
      rs2        = b;
      immB       = imm;
      immJ       = imm;
      immI       = imm;
      predTaken  = pred;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkBus(input string tag, input logic v, input logic [XLEN-1:0] p,
                           input logic f);
      checkOutput({tag, ".valid"}, {31'd0, redirIf.redirectValid}, {31'd0, v});
      checkOutput({tag, ".pc"},    redirIf.redirectPc, p);
      checkOutput({tag, ".flush"}, {31'd0, redirIf.flush}, {31'd0, f});
   endtask

   task automatic checkCounts(input string tag, input int br, input int mp);
      checkOutput({tag, ".br"}, {28'd0, brCount}, br[31:0]);
      checkOutput({tag, ".mp"}, {28'd0, mpCount}, mp[31:0]);
   endtask

   // Directed sequence following the block's recovery and counting behaviour.
   initial begin
      checks  = 0;
      passes  = 0;
      aresetn = 1'b0;
      stall   = 1'b0;
      cntClr  = 1'b0;
      redirIf.redirectReady = 1'b1;
      applyStimulus(1'b1, K_JALR, 3'b000, 32'h40, 32'h1003, 32'h0, 32'h0, 1'b0);

      // Reset held with a mispredicting JALR present
      tick();
      tick();
      checkBus("reset", 1'b0, 32'h0, 1'b0);
      checkCounts("reset", 0, 0);

      // Backward BNE with equal operands, predicted taken -> falls through
      aresetn = 1'b1;
      applyStimulus(1'b1, K_BR, 3'b001, 32'h100, 32'd5, 32'd5, 32'hFFFF_FFF8, 1'b1);
      tick();
      checkBus("bne.redir", 1'b1, 32'h104, 1'b1);
      checkCounts("bne", 1, 1);
      applyStimulus(1'b0, K_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      checkBus("bne.squash", 1'b0, 32'h104, 1'b1);
      tick();
      checkOutput("bne.idle.flush", {31'd0, redirIf.flush}, 32'd0);

      // BLT: -1 < 1 signed, predicted not taken -> redirect to target
      applyStimulus(1'b1, K_BR, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
      tick();
      checkBus("blt.redir", 1'b1, 32'h210, 1'b1);
      checkCounts("blt", 2, 2);
      applyStimulus(1'b0, K_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();

      // BLTU: 0xFFFFFFFF < 1 unsigned is false, prediction correct
      applyStimulus(1'b1, K_BR, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0);
      tick();
      checkOutput("bltu.valid", {31'd0, redirIf.redirectValid}, 32'd0);
      checkOutput("bltu.flush", {31'd0, redirIf.flush}, 32'd0);
      checkCounts("bltu", 3, 2);

      // JALR with LSB cleared; fetch stalls the handshake for three edges
      redirIf.redirectReady = 1'b0;
      applyStimulus(1'b1, K_JALR, 3'b000, 32'h40, 32'h1003, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkBus($sformatf("jalr.wait%0d", i), 1'b1, 32'h1002, 1'b1);
      end
      redirIf.redirectReady = 1'b1;
      tick();
      checkBus("jalr.squash", 1'b0, 32'h1002, 1'b1);
      checkCounts("jalr.wrongpath", 4, 3);
      applyStimulus(1'b0, K_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      checkOutput("jalr.idle.flush", {31'd0, redirIf.flush}, 32'd0);

      // Correctly predicted JAL, then a non-control op predicted taken at the top of memory
      applyStimulus(1'b1, K_JAL, 3'b000, 32'h300, 32'h0, 32'h0, 32'h20, 1'b1);
      tick();
      checkOutput("jal.valid", {31'd0, redirIf.redirectValid}, 32'd0);
      checkCounts("jal", 5, 3);
      applyStimulus(1'b1, K_NONE, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b1);
      tick();
      checkBus("nonctl.redir", 1'b1, 32'h0, 1'b1);
      checkCounts("nonctl", 5, 4);
      applyStimulus(1'b0, K_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();

      // Clear together with a resolve wins
      cntClr = 1'b1;
      applyStimulus(1'b1, K_BR, 3'b000, 32'h400, 32'd7, 32'd7, 32'h8, 1'b1);
      tick();
      checkCounts("clr", 0, 0);
      cntClr = 1'b0;

      // Back-to-back correct BEQs saturate the 4-bit branch counter
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i == 13) checkCounts("sat.mid", 14, 0);
      end
      checkCounts("sat", 15, 0);
      checkOutput("sat.valid", {31'd0, redirIf.redirectValid}, 32'd0);

      // Stall blocks sampling of a mispredicting branch
      stall = 1'b1;
      applyStimulus(1'b1, K_BR, 3'b001, 32'h500, 32'd3, 32'd3, 32'h40, 1'b1);
      tick();
      tick();
      checkBus("stall", 1'b0, 32'h0, 1'b0);
      checkCounts("stall", 15, 0);

      // Reserved funct3 resolves not taken; br stays saturated, mp counts
      stall = 1'b0;
      redirIf.redirectReady = 1'b0;
      applyStimulus(1'b1, K_BR, 3'b010, 32'h500, 32'd3, 32'd3, 32'h40, 1'b1);
      tick();
      checkBus("f3res.redir", 1'b1, 32'h504, 1'b1);
      checkCounts("f3res", 15, 1);

      // Reset in the middle of a pending redirect
      aresetn = 1'b0;
      tick();
      checkBus("midreset", 1'b0, 32'h0, 1'b0);
      checkCounts("midreset", 0, 0);
      aresetn = 1'b1;
      applyStimulus(1'b0, K_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
